fir_mac_core: RTL and testbench
===============================

// Module: fir_mac_core
// PURPOSE
//  Sequential-MAC FIR datapath sitting behind the fir_filter AXI4-Lite register bank.
//  The register bank forwards written samples over s_* and coefficient writes over coef_*.
//  It reads filtered results back over m_*.
//  One multiplier is reused across TAPS cycles per sample; unsigned arithmetic throughout.
// PARAMETERS
//  TAPS    8   number of filter taps (power of 2, >=2)
//  DATA_W  8   sample width, unsigned
//  COEF_W  8   coefficient width, unsigned
//  OUT_W   16  result width on m_data
//  localparam ACC_W = DATA_W+COEF_W+$clog2(TAPS)  (19 at defaults; accumulator never overflows)
// PORTS
//  ACLK        in   1              clock, all logic on rising edge
//  ARESET      in   1              synchronous reset, active-high
//  s_valid     in   1              input sample valid
//  s_ready     out  1              core can accept a sample
//  s_data      in   DATA_W         input sample x[n]
//  coef_we     in   1              coefficient write strobe
//  coef_addr   in   $clog2(TAPS)   tap index k
//  coef_wdata  in   COEF_W         value for h[k]
//  m_valid     out  1              result valid
//  m_ready     in   1              consumer accepts result
//  m_data      out  OUT_W          y[n] = sum_k h[k]*x[n-k]
//  busy        out  1              state != IDLE
// BEHAVIOUR
//  Reset (ARESET=1 at a clock edge, any state):
//   - state=IDLE, m_valid=0, m_data=0, busy=0, s_ready=1.
//   - Delay line x[0..TAPS-1]=0, acc=0, tap counter=0.
//   - All h[k]=1.
//  FSM IDLE -> MAC -> DONE -> IDLE:
//   - IDLE: s_ready=1. On s_valid&s_ready, shift x[k]<=x[k-1] and x[0]<=s_data, clear acc, k=0, go MAC.
//   - MAC: each cycle acc<=acc+h[k]*x[k], k<=k+1. After the cycle with k=TAPS-1, go DONE.
//   - DONE: m_valid=1, m_data=result(acc), both held stable. On m_ready, go IDLE and drop m_valid.
//  Latency: m_valid rises exactly TAPS+1 cycles after the accepting edge (9 at defaults).
//  Throughput: with m_ready=1, one sample per TAPS+2 cycles.
//  s_ready=(state==IDLE) and m_valid=(state==DONE), both decoded from registered state.
//   - A sample offered in DONE is not taken, even if m_ready=1 in the same cycle; it is accepted on the next (IDLE) edge.
//  Coefficient writes:
//   - Applied only when state==IDLE; h[coef_addr]<=coef_wdata.
//   - coef_we while busy is silently dropped, so coefficients cannot change mid-sum.
//   - A write and a sample accept on the same IDLE edge: the new h[k] is used for that sample.
//  Delay line persists across samples (true FIR history); only ARESET clears it.
//  No skid buffer; s_data is sampled only on the accepting edge.
// CONFIGURATION
//  FIR_SAT_EN defined: m_data = (acc > 2^OUT_W-1) ? 2^OUT_W-1 : acc[OUT_W-1:0]  (unsigned clamp).
//  FIR_SAT_EN undefined: m_data = acc[OUT_W-1:0]  (wrap, upper bits discarded).
//  Latency, handshake and FSM are identical in both builds.
// TESTING
//  1 Assert ARESET 5 cycles -> m_valid=0, s_ready=1, busy=0. Next sample 3 -> m_data=3 (h=1, history zero).
//  2 Impulse: write h[k]=k+1 for k=0..7, then feed 1,0,0,0,0,0,0,0 with m_ready=1.
//    -> m_data=1,2,...,8, each m_valid exactly 9 cycles after its accept.
//  3 Backpressure: hold m_ready=0 for 20 cycles in DONE.
//    -> m_valid, m_data stable; s_ready=0; offered sample not shifted in until after m_ready.
//  4 Write h[0]=100 while busy -> result unaffected. Same write in IDLE -> next result uses 100.
//  5 Overflow: all h=255, eight samples of 255 -> acc=520200.
//    FIR_SAT_EN: m_data=0xFFFF. Otherwise m_data=0xF008.
//  6 ARESET mid-MAC (k=4) -> next cycle IDLE, m_valid=0, no result emitted, history and h back to reset values.

Source files
------------

// File: rtl/fir_mac_core_if.sv
// Handshake/coefficient bundle between the fir_filter register bank (master) and fir_mac_core
// (slave).
interface fir_mac_core_if #(
    parameter int unsigned TAPS   = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 16
);
    localparam int unsigned AW = $clog2(TAPS);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_wdata, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_wdata, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/fir_mac_core.sv
// Sequential-MAC FIR core: one multiplier reused over TAPS cycles per sample, unsigned math.
// Build option: define FIR_SAT_EN to clamp m_data instead of wrapping the accumulator.
module fir_mac_core #(
    parameter int unsigned TAPS   = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 16
) (
    input  logic               ACLK,
    input  logic               ARESET,
    fir_mac_core_if.slave      bus,
    output logic               busy
);
    localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int unsigned KW     = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   x_q [TAPS];
    logic [DATA_W-1:0]   x_d [TAPS];
    logic [COEF_W-1:0]   h_q [TAPS];
    logic [COEF_W-1:0]   h_d [TAPS];
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [KW-1:0]       k_q, k_d;
    logic [PROD_W-1:0]   prod;
    logic                accept;
    logic                coef_wr;
    logic [OUT_W-1:0]    result;

    assign prod = {{DATA_W{1'b0}}, h_q[k_q]} * {{COEF_W{1'b0}}, x_q[k_q]};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        acc_d   = acc_q;
        k_d     = k_q;
        accept  = bus.s_valid && (state_q == StIdle);
        // Writes outside IDLE are dropped so a running sum always sees one coefficient set.
        coef_wr = bus.coef_we && (state_q == StIdle);

        if (coef_wr) begin
            h_d[bus.coef_addr] = bus.coef_wdata;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]  = bus.s_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + KW'(1);
                if (k_q == KW'(TAPS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
            acc_q   <= '0;
            k_q     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= COEF_W'(1);
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            x_q     <= x_d;
            h_q     <= h_d;
        end
    end

`ifdef FIR_SAT_EN
    assign result = (acc_q > ACC_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : acc_q[OUT_W-1:0];
`else
    assign result = acc_q[OUT_W-1:0];
`endif

    // Handshake outputs decode registered state only; no combinational path from inputs.
    assign bus.s_ready = (state_q == StIdle);
    assign bus.m_valid = (state_q == StDone);
    assign bus.m_data  = result;
    assign busy        = (state_q != StIdle);
endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench for fir_mac_core: directed scenarios plus random samples/coefficients
// scored against an arithmetic FIR reference model.
module tb_fir_mac_core;
    localparam int unsigned TAPS   = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned OUT_W  = 16;
`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    int unsigned h_m  [TAPS];
    int unsigned hist [TAPS];

    fir_mac_core_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus_if ();

    fir_mac_core #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus_if),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            h_m[i]  = 1;
            hist[i] = 0;
        end
    endfunction

    function automatic logic [31:0] model_y();
        longint sum = 0;
        for (int i = 0; i < TAPS; i++) sum += longint'(h_m[i]) * longint'(hist[i]);
        if (SAT && sum > 65535) return 32'hFFFF;
        return 32'(sum % 65536);
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int k, input int unsigned v);
        bus_if.coef_we    = 1'b1;
        bus_if.coef_addr  = 3'(k);
        bus_if.coef_wdata = 8'(v);
        h_m[k] = v;
        step();
        bus_if.coef_we = 1'b0;
    endtask

    // Returns just after the accepting edge; the model history is shifted here.
    task automatic start_sample(input int unsigned d);
        int n = 0;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 8'(d);
        while (!bus_if.s_ready && n < 50) begin
            step();
            n++;
        end
        check("s_ready_before_accept", 32'(bus_if.s_ready), 32'd1);
        accept_cyc = cyc;
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        step();
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 8'($urandom);
    endtask

    task automatic finish_sample(input string tag, output logic [31:0] got);
        int n = 0;
        while (!bus_if.m_valid && n < 60) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(TAPS + 1));
        check(tag, 32'(bus_if.m_data), model_y());
        got = 32'(bus_if.m_data);
        bus_if.m_ready = 1'b1;
        step();
        bus_if.m_ready = 1'b0;
        check({tag, "_mvalid_drop"}, 32'(bus_if.m_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] held;
        bus_if.s_valid    = 1'b0;
        bus_if.s_data     = '0;
        bus_if.coef_we    = 1'b0;
        bus_if.coef_addr  = '0;
        bus_if.coef_wdata = '0;
        bus_if.m_ready    = 1'b0;
        model_reset();

        // 1: reset state and first sample with default coefficients
        do_reset(5);
        check("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
        check("rst_s_ready", 32'(bus_if.s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_data", 32'(bus_if.m_data), 32'd0);
        start_sample(3);
        check("busy_in_mac", 32'(busy), 32'd1);
        finish_sample("first_sample", got);
        check("first_sample_lit", got, 32'd3);

        // 2: impulse response over clean history
        do_reset(2);
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        for (int n = 0; n < TAPS; n++) begin
            start_sample(n == 0 ? 1 : 0);
            finish_sample("impulse", got);
            check("impulse_lit", got, 32'(n + 1));
        end

        // 3: backpressure; a sample offered in DONE must wait for IDLE
        start_sample(9);
        for (int n = 0; n < 60 && !bus_if.m_valid; n++) step();
        held = 32'(bus_if.m_data);
        check("bp_value", held, model_y());
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 8'd77;
        for (int n = 0; n < 20; n++) begin
            step();
            check("bp_m_valid", 32'(bus_if.m_valid), 32'd1);
            check("bp_m_data", 32'(bus_if.m_data), held);
            check("bp_s_ready", 32'(bus_if.s_ready), 32'd0);
        end
        bus_if.m_ready = 1'b1;
        step();
        bus_if.m_ready = 1'b0;
        check("bp_idle_after_ready", 32'(bus_if.s_ready), 32'd1);
        start_sample(77);
        finish_sample("bp_next", got);

        // 4: coefficient write while busy is dropped; in IDLE on the accept edge it applies
        start_sample(5);
        repeat (3) step();
        bus_if.coef_we    = 1'b1;
        bus_if.coef_addr  = 3'd0;
        bus_if.coef_wdata = 8'd100;
        step();
        bus_if.coef_we = 1'b0;
        finish_sample("busy_write_dropped", got);
        bus_if.coef_we    = 1'b1;
        bus_if.coef_addr  = 3'd0;
        bus_if.coef_wdata = 8'd100;
        h_m[0] = 100;
        start_sample(6);
        bus_if.coef_we = 1'b0;
        finish_sample("idle_write_same_edge", got);

        // random coefficients and samples
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) write_coef($urandom_range(0, TAPS - 1), $urandom_range(0, 255));
            start_sample($urandom_range(0, 255));
            finish_sample("random", got);
        end

        // 5: accumulator wider than m_data
        for (int k = 0; k < TAPS; k++) write_coef(k, 255);
        for (int n = 0; n < TAPS; n++) begin
            start_sample(255);
            finish_sample("overflow", got);
        end
        check("overflow_lit", got, SAT ? 32'hFFFF : 32'hF008);

        // 6: reset in the middle of a sum
        write_coef(2, 50);
        start_sample(200);
        repeat (4) step();
        check("mid_busy", 32'(busy), 32'd1);
        do_reset(1);
        check("mid_rst_m_valid", 32'(bus_if.m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(bus_if.s_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        begin
            int seen = 0;
            for (int n = 0; n < 12; n++) begin
                step();
                if (bus_if.m_valid) seen++;
            end
            check("mid_rst_no_result", 32'(seen), 32'd0);
        end
        start_sample(5);
        finish_sample("after_mid_rst", got);
        check("after_mid_rst_lit", got, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
